// File: rtl/riscv_fetch_pkg.sv
// Shared types for the instruction-fetch front end: FSM states, queue entry
// layout and the sequential PC increment.
package riscv_fetch_pkg;

  typedef enum logic {
    RUN,
    DISCARD
  } fetch_state_t;

  localparam int unsigned PC_STEP    = 4;
  localparam int unsigned FETCH_XLEN = 32;
  localparam int unsigned FETCH_ILEN = 32;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_ILEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries. The extra pointer bit tells full from empty;
// flush empties the queue and wins over any same-cycle push or pop.
module fetch_queue
  import riscv_fetch_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = fetch_entry_t,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  entry_t        wdata_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o,
  output entry_t        head_o
);

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  entry_t      mem_q [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the pointers alone decide what is visible.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction-fetch stage with a prefetch queue between the I-cache and decode.
// Redirects during an outstanding miss park the target until the cache releases.
module instr_fetch_queue
  import riscv_fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     ILEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  localparam int unsigned    CW       = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ICACHE_ren,
  output logic [XLEN-3:0]   ICACHE_addr,
  input  logic              ICACHE_stall,
  input  logic [ILEN-1:0]   ICACHE_rdata,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [ILEN-1:0]   out_instr,
  output logic [CW-1:0]     occupancy
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } entry_t;

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] pending_pc_q, pending_pc_d;
  logic [XLEN-1:0] redirect_target;
  logic            response;
  logic            q_push, q_pop, q_full, q_empty;
  logic [CW-1:0]   q_count;
  entry_t          q_head, q_wdata;

  assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};

  // In DISCARD the queue is empty, so ren stays high on the parked address.
  assign ICACHE_ren  = !rst && ((state_q == DISCARD) || !q_full);
  assign ICACHE_addr = fetch_pc_q[XLEN-1:2];
  assign response    = ICACHE_ren && !ICACHE_stall;

  assign q_push  = (state_q == RUN) && response && !redirect_valid;
  assign q_pop   = out_valid && out_ready;
  assign q_wdata = '{pc: fetch_pc_q, instr: ICACHE_rdata};

  assign out_valid = !rst && !q_empty;
  assign out_pc    = out_valid ? q_head.pc : '0;
  assign out_instr = out_valid ? q_head.instr : '0;
  assign occupancy = rst ? '0 : q_count;

  fetch_queue #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .push_i  (q_push),
    .pop_i   (q_pop),
    .flush_i (redirect_valid),
    .wdata_i (q_wdata),
    .full_o  (q_full),
    .empty_o (q_empty),
    .count_o (q_count),
    .head_o  (q_head)
  );

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    pending_pc_d = pending_pc_q;
    unique case (state_q)
      RUN: begin
        if (redirect_valid) begin
          if (ICACHE_ren && ICACHE_stall) begin
            pending_pc_d = redirect_target;
            state_d      = DISCARD;
          end else begin
            fetch_pc_d = redirect_target;
          end
        end else if (response) begin
          fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
        end
      end
      DISCARD: begin
        if (redirect_valid) pending_pc_d = redirect_target;
        // A redirect in the release cycle is the newest target.
        if (!ICACHE_stall) begin
          fetch_pc_d = redirect_valid ? redirect_target : pending_pc_q;
          state_d    = RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      fetch_pc_q   <= RESET_PC;
      pending_pc_q <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      pending_pc_q <= pending_pc_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench: the bench plays the I-cache and decode, and compares the
// DUT every cycle against a queue-based model of the fetch stage.
module tb_instr_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ICACHE_ren;
  logic [29:0] ICACHE_addr;
  logic        ICACHE_stall = 1'b0;
  logic [31:0] ICACHE_rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [2:0]  occupancy;

  instr_fetch_queue #(
    .XLEN     (32),
    .ILEN     (32),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ICACHE_ren     (ICACHE_ren),
    .ICACHE_addr    (ICACHE_addr),
    .ICACHE_stall   (ICACHE_stall),
    .ICACHE_rdata   (ICACHE_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .occupancy      (occupancy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instrFor(input logic [29:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A0F0F;
  endfunction

  assign ICACHE_rdata = instrFor(ICACHE_addr);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } modelEntry_t;

  modelEntry_t modelQ[$];
  logic [31:0] modelPc         = RESET_PC;
  logic [31:0] modelPending    = '0;
  bit          modelDiscarding = 1'b0;
  int          checks = 0;
  int          errors = 0;

  function automatic void compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic checkOutput();
    logic        expRen, expValid;
    logic [31:0] expPc, expInstr;
    expRen   = !rst && (modelDiscarding || modelQ.size() < DEPTH);
    expValid = !rst && modelQ.size() > 0;
    expPc    = expValid ? modelQ[0].pc : 32'h0;
    expInstr = expValid ? modelQ[0].instr : 32'h0;
    compare("ren", {31'b0, ICACHE_ren}, {31'b0, expRen});
    if (!rst) compare("addr", {2'b0, ICACHE_addr}, {2'b0, modelPc[31:2]});
    compare("outValid", {31'b0, out_valid}, {31'b0, expValid});
    compare("outPc", out_pc, expPc);
    compare("outInstr", out_instr, expInstr);
    compare("occupancy", {29'b0, occupancy}, rst ? 32'h0 : 32'(modelQ.size()));
  endtask

  // Advance the model across the coming clock edge using the current inputs.
  task automatic modelStep();
    bit          ren, hit, pop;
    logic [31:0] target;
    target = {redirect_pc[31:2], 2'b00};
    if (rst) begin
      modelQ.delete();
      modelPc         = RESET_PC;
      modelDiscarding = 1'b0;
    end else begin
      ren = modelDiscarding || modelQ.size() < DEPTH;
      hit = ren && !ICACHE_stall;
      pop = modelQ.size() > 0 && out_ready;
      if (modelDiscarding) begin
        if (redirect_valid) begin
          modelPending = target;
          modelQ.delete();
        end
        if (!ICACHE_stall) begin
          modelPc         = modelPending;
          modelDiscarding = 1'b0;
        end
      end else if (redirect_valid) begin
        modelQ.delete();
        if (ren && ICACHE_stall) begin
          modelPending    = target;
          modelDiscarding = 1'b1;
        end else begin
          modelPc = target;
        end
      end else begin
        if (pop) void'(modelQ.pop_front());
        if (hit) begin
          modelQ.push_back('{pc: modelPc, instr: instrFor(modelPc[31:2])});
          modelPc = modelPc + 32'd4;
        end
      end
    end
  endtask

  task automatic applyStimulus(input bit r, input bit redir, input logic [31:0] rpc,
                               input bit rdy, input bit stall);
    @(negedge clk);
    rst            = r;
    redirect_valid = redir;
    redirect_pc    = rpc;
    out_ready      = rdy;
    ICACHE_stall   = stall;
    #1;
    checkOutput();
    modelStep();
  endtask

  initial begin
    // Reset, then always-hit streaming.
    repeat (3) applyStimulus(1, 0, 0, 1, 0);
    compare("rstRen", {31'b0, ICACHE_ren}, 32'h0);
    compare("rstOcc", {29'b0, occupancy}, 32'h0);
    applyStimulus(0, 0, 0, 1, 0);
    compare("firstAddr", {2'b0, ICACHE_addr}, 32'h40);
    applyStimulus(0, 0, 0, 1, 0);
    compare("secondAddr", {2'b0, ICACHE_addr}, 32'h41);
    compare("firstPc", out_pc, 32'h100);
    repeat (6) applyStimulus(0, 0, 0, 1, 0);

    // Decode back-pressure fills the queue, then a redirect with 3 entries queued.
    repeat (2) applyStimulus(1, 0, 0, 1, 0);
    repeat (10) applyStimulus(0, 0, 0, 0, 0);
    compare("fullOcc", {29'b0, occupancy}, 32'h4);
    compare("fullRen", {31'b0, ICACHE_ren}, 32'h0);
    compare("fullAddr", {2'b0, ICACHE_addr}, 32'h44);
    applyStimulus(0, 0, 0, 1, 0);
    compare("drainPc", out_pc, 32'h100);
    applyStimulus(0, 1, 32'h2003, 1, 0);
    compare("preRedirOcc", {29'b0, occupancy}, 32'h3);
    applyStimulus(0, 0, 0, 1, 0);
    compare("redirValid", {31'b0, out_valid}, 32'h0);
    compare("redirAddr", {2'b0, ICACHE_addr}, 32'h800);
    applyStimulus(0, 0, 0, 1, 0);
    compare("redirPc", out_pc, 32'h2000);

    // Redirect during a 5-cycle miss at 0x108.
    repeat (2) applyStimulus(1, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 1, 0);
    for (int i = 2; i <= 7; i++) begin
      applyStimulus(0, i == 3, 32'h500, 1, i <= 6);
      compare("missHold", {2'b0, ICACHE_addr}, 32'h42);
    end
    applyStimulus(0, 0, 0, 1, 0);
    compare("missRedirAddr", {2'b0, ICACHE_addr}, 32'h140);
    applyStimulus(0, 0, 0, 1, 0);
    compare("missRedirPc", out_pc, 32'h500);

    // Two redirects inside one miss: the later one wins.
    repeat (2) applyStimulus(1, 0, 0, 1, 0);
    for (int i = 0; i <= 5; i++)
      applyStimulus(0, i == 1 || i == 3, (i == 1) ? 32'h300 : 32'h400, 1, i < 5);
    applyStimulus(0, 0, 0, 1, 0);
    compare("lastWinsAddr", {2'b0, ICACHE_addr}, 32'h100);

    // Push, pop and redirect together; then reset in the middle of a miss.
    applyStimulus(0, 1, 32'h700, 1, 0);
    applyStimulus(0, 0, 0, 0, 1);
    compare("flushOcc", {29'b0, occupancy}, 32'h0);
    compare("flushAddr", {2'b0, ICACHE_addr}, 32'h1C0);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 1);
    compare("midMissRstRen", {31'b0, ICACHE_ren}, 32'h0);
    applyStimulus(0, 0, 0, 1, 0);
    compare("postRstAddr", {2'b0, ICACHE_addr}, 32'h40);
    compare("postRstOcc", {29'b0, occupancy}, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++)
      applyStimulus($urandom_range(199) == 0, $urandom_range(99) < 6, $urandom,
                    $urandom_range(99) < 70, $urandom_range(99) < 30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
